// File: rtl/picorisc_fetch_pkg.sv
// Shared types and defaults for the picoRISC instruction-fetch sequencer.
package picorisc_fetch_pkg;

  localparam int PSIZE_DEF = 5;
  localparam int ISIZE_DEF = 20;

  typedef logic [PSIZE_DEF-1:0] pc_t;
  typedef logic [ISIZE_DEF-1:0] instr_t;

  localparam instr_t HALT_WORD_DEF = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus: program memory address/data, IR handshake to decode, redirect requests and status.
interface instr_fetch_ctrl_if
  import picorisc_fetch_pkg::*;
#(
  parameter int PSIZE = PSIZE_DEF,
  parameter int ISIZE = ISIZE_DEF
);
  logic [PSIZE-1:0] pc_addr;
  logic [ISIZE-1:0] instr_code;
  logic [ISIZE-1:0] ir;
  logic             ir_valid;
  logic             ir_ready;
  logic             run;
  logic             branch_req;
  logic [PSIZE-1:0] branch_target;
  logic             call_req;
  logic             ret_req;
  logic             halted;
  logic             fault;

  modport master (
    output pc_addr, ir, ir_valid, halted, fault,
    input  instr_code, ir_ready, run, branch_req, branch_target, call_req, ret_req
  );

  modport slave (
    input  pc_addr, ir, ir_valid, halted, fault,
    output instr_code, ir_ready, run, branch_req, branch_target, call_req, ret_req
  );
endinterface

// File: rtl/fetch_ret_stack.sv
// Return-address LIFO for call/return; caller guarantees no push when full and no pop when empty.
module fetch_ret_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_cnt;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_top_idx;

  assign w_wr_idx  = AW'(r_cnt);
  assign w_top_idx = AW'(r_cnt - CW'(1));
  assign o_data    = r_mem[w_top_idx];
  assign o_full    = (r_cnt == CW'(DEPTH));
  assign o_empty   = (r_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_push && !o_full) begin
      r_cnt <= r_cnt + CW'(1);
    end else if (i_pop && !o_empty) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Storage needs no reset; only the count defines what is live.
  always_ff @(posedge i_clk) begin
    if (i_push && !o_full) r_mem[w_wr_idx] <= i_data;
  end
endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, latches prog_mem data into IR, handles stall/redirect/halt.
// Optional call/return stack built only when FETCH_CALL_STACK_EN is defined.
//   state | meaning
//   IDLE  | not fetching; redirects move pc, decode may still drain ir
//   FETCH | capturing one instruction per cycle when ir is free or accepted
//   HALT  | stopped on HALT_WORD or stack fault; left only by reset
module instr_fetch_ctrl
  import picorisc_fetch_pkg::*;
#(
  parameter int               PSIZE       = PSIZE_DEF,
  parameter int               ISIZE       = ISIZE_DEF,
  parameter logic [ISIZE-1:0] HALT_WORD   = {ISIZE{1'b1}},
  parameter int               STACK_DEPTH = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  instr_fetch_ctrl_if.master  bus
);
  fetch_state_e     r_state;
  logic [PSIZE-1:0] r_pc;
  logic [ISIZE-1:0] r_ir;
  logic             r_ir_valid;
  logic             r_halted;
  logic             r_fault;

  logic             w_ret_go;
  logic             w_call_go;
  logic             w_stk_fault;
  logic [PSIZE-1:0] w_top;
  logic             w_redir;
  logic [PSIZE-1:0] w_target;
  logic             w_active;

  assign w_active = (r_state != HALT);

`ifdef FETCH_CALL_STACK_EN
  logic w_full;
  logic w_empty;

  // Return beats call; an op that would over/underflow becomes a fault instead.
  assign w_ret_go    = w_active & bus.ret_req & ~w_empty;
  assign w_call_go   = w_active & ~bus.ret_req & bus.call_req & ~w_full;
  assign w_stk_fault = w_active & (bus.ret_req ? w_empty : (bus.call_req & w_full));

  fetch_ret_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (PSIZE)
  ) u_ret_stack (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_call_go),
    .i_pop   (w_ret_go),
    .i_data  (r_pc),
    .o_data  (w_top),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
`else
  logic w_unused_stack;
  localparam int STACK_DEPTH_UNUSED = STACK_DEPTH;

  assign w_ret_go       = 1'b0;
  assign w_call_go      = 1'b0;
  assign w_stk_fault    = 1'b0;
  assign w_top          = '0;
  assign w_unused_stack = bus.call_req ^ bus.ret_req;
`endif

  assign w_redir  = w_ret_go | w_call_go | bus.branch_req;
  assign w_target = w_ret_go ? w_top : bus.branch_target;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_pc       <= '0;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
      r_halted   <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      if (r_ir_valid && bus.ir_ready) r_ir_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_stk_fault) begin
            r_fault  <= 1'b1;
            r_halted <= 1'b1;
            r_state  <= HALT;
          end else begin
            if (w_redir) r_pc <= w_target;
            if (bus.run) r_state <= FETCH;
          end
        end
        FETCH: begin
          if (w_stk_fault) begin
            r_fault  <= 1'b1;
            r_halted <= 1'b1;
            r_state  <= HALT;
          end else if (w_redir) begin
            r_pc       <= w_target;
            r_ir_valid <= 1'b0;
            if (!bus.run) r_state <= IDLE;
          end else if (bus.run && (!r_ir_valid || bus.ir_ready)) begin
            r_ir       <= bus.instr_code;
            r_ir_valid <= 1'b1;
            r_pc       <= r_pc + PSIZE'(1);
            if (bus.instr_code == HALT_WORD) begin
              r_halted <= 1'b1;
              r_state  <= HALT;
            end
          end else if (!bus.run) begin
            r_state <= IDLE;
          end
        end
        HALT: begin
          r_state <= HALT;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.pc_addr  = r_pc;
  assign bus.ir       = r_ir;
  assign bus.ir_valid = r_ir_valid;
  assign bus.halted   = r_halted;
  assign bus.fault    = r_fault;
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: accepted IR words are checked against a queue of expected words.
module tb_instr_fetch_ctrl;
  logic        clk;
  logic        rst;
  logic [19:0] mem [32];
  logic [19:0] exp_q [$];
  int          n_checks;
  int          n_errors;

  instr_fetch_ctrl_if #(.PSIZE(5), .ISIZE(20)) bus ();

  instr_fetch_ctrl dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  assign bus.instr_code = mem[bus.pc_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: every accepted ir must match the oldest expected word.
  always @(posedge clk) begin
    if (!rst && bus.ir_valid === 1'b1 && bus.ir_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $error("FAIL accept_unexpected: observed=%0h expected=no accept", bus.ir);
      end else begin
        logic [19:0] w;
        w = exp_q.pop_front();
        assert (bus.ir === w) else begin
          n_errors++;
          $error("FAIL accept_ir: observed=%0h expected=%0h", bus.ir, w);
        end
      end
    end
  end

  initial begin
    int pcs [4];
    int tg [4];
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 32; i++) mem[i] = 20'(i * 37 + 5);
    rst = 1'b1;
    bus.run = 1'b0;
    bus.ir_ready = 1'b0;
    bus.branch_req = 1'b0;
    bus.branch_target = '0;
    bus.call_req = 1'b0;
    bus.ret_req = 1'b0;
    step(2);
    chk("rst_pc", 32'(bus.pc_addr), 0);
    chk("rst_ir", 32'(bus.ir), 0);
    chk("rst_valid", 32'(bus.ir_valid), 0);
    chk("rst_halted", 32'(bus.halted), 0);
    chk("rst_fault", 32'(bus.fault), 0);

    // Sequential fetch
    rst = 1'b0;
    bus.run = 1'b1;
    bus.ir_ready = 1'b1;
    step(1);
    chk("seq_pc0", 32'(bus.pc_addr), 0);
    chk("seq_valid0", 32'(bus.ir_valid), 0);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      chk("seq_pc", 32'(bus.pc_addr), 32'(k));
      chk("seq_ir", 32'(bus.ir), 32'(mem[k-1]));
      chk("seq_valid", 32'(bus.ir_valid), 1);
      exp_q.push_back(mem[k-1]);
    end

    // Stall at pc=4
    bus.ir_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("stall_pc", 32'(bus.pc_addr), 4);
      chk("stall_ir", 32'(bus.ir), 32'(mem[3]));
    end
    bus.ir_ready = 1'b1;
    step(1);
    chk("resume_pc", 32'(bus.pc_addr), 5);
    chk("resume_ir", 32'(bus.ir), 32'(mem[4]));

    // Branch while decode is stalled flushes ir
    bus.ir_ready = 1'b0;
    bus.branch_req = 1'b1;
    bus.branch_target = 5'b10100;
    step(1);
    bus.branch_req = 1'b0;
    chk("br_pc", 32'(bus.pc_addr), 20);
    chk("br_flush", 32'(bus.ir_valid), 0);
    step(1);
    chk("br_ir", 32'(bus.ir), 32'(mem[20]));
    chk("br_pc_next", 32'(bus.pc_addr), 21);
    exp_q.push_back(mem[20]);
    bus.ir_ready = 1'b1;
    step(1);
    chk("br_ir2", 32'(bus.ir), 32'(mem[21]));
    exp_q.push_back(mem[21]);
    bus.run = 1'b0;
    step(1);
    chk("idle_valid", 32'(bus.ir_valid), 0);
    chk("idle_pc", 32'(bus.pc_addr), 22);
    chk("queue_drained", 32'(exp_q.size()), 0);

    // Redirect in IDLE, wrap 31->0, halt at address 2
    bus.branch_req = 1'b1;
    bus.branch_target = 5'd30;
    step(1);
    bus.branch_req = 1'b0;
    chk("idle_br_pc", 32'(bus.pc_addr), 30);
    mem[2] = 20'hFFFFF;
    bus.run = 1'b1;
    step(1);
    chk("wrap_pc30", 32'(bus.pc_addr), 30);
    pcs = '{31, 0, 1, 2};
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("wrap_pc", 32'(bus.pc_addr), 32'(pcs[i]));
      chk("wrap_ir", 32'(bus.ir), 32'(mem[(pcs[i] + 31) % 32]));
      exp_q.push_back(mem[(pcs[i] + 31) % 32]);
    end
    step(1);
    chk("halt_pc", 32'(bus.pc_addr), 3);
    chk("halt_ir", 32'(bus.ir), 32'h000F_FFFF);
    chk("halt_flag", 32'(bus.halted), 1);
    chk("halt_valid", 32'(bus.ir_valid), 1);
    exp_q.push_back(20'hFFFFF);
    step(1);
    chk("halt_drain", 32'(bus.ir_valid), 0);
    bus.branch_req = 1'b1;
    bus.branch_target = 5'd7;
    step(2);
    bus.branch_req = 1'b0;
    chk("halt_frozen_pc", 32'(bus.pc_addr), 3);
    chk("halt_sticky", 32'(bus.halted), 1);

    // Reset out of HALT, then reset mid-stall
    mem[2] = 20'(2 * 37 + 5);
    rst = 1'b1;
    bus.ir_ready = 1'b0;
    step(1);
    chk("rst_from_halt", 32'(bus.halted), 0);
    rst = 1'b0;
    step(4);
    chk("stall2_pc", 32'(bus.pc_addr), 1);
    chk("stall2_valid", 32'(bus.ir_valid), 1);
    rst = 1'b1;
    step(1);
    chk("midstall_pc", 32'(bus.pc_addr), 0);
    chk("midstall_ir", 32'(bus.ir), 0);
    chk("midstall_valid", 32'(bus.ir_valid), 0);
    chk("midstall_halted", 32'(bus.halted), 0);
    chk("midstall_fault", 32'(bus.fault), 0);
    rst = 1'b0;
    bus.ir_ready = 1'b1;
    step(2);
    chk("restart_pc", 32'(bus.pc_addr), 1);
    chk("restart_ir", 32'(bus.ir), 32'(mem[0]));
    exp_q.push_back(mem[0]);
    bus.run = 1'b0;
    step(1);
    chk("queue_drained2", 32'(exp_q.size()), 0);

`ifdef FETCH_CALL_STACK_EN
    tg = '{8, 12, 16, 24};
    bus.branch_req = 1'b1;
    bus.branch_target = 5'd3;
    step(1);
    bus.branch_req = 1'b0;
    bus.call_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.branch_target = 5'(tg[i]);
      step(1);
      chk("call_pc", 32'(bus.pc_addr), 32'(tg[i]));
    end
    bus.call_req = 1'b0;
    bus.ret_req = 1'b1;
    pcs = '{16, 12, 8, 3};
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("ret_pc", 32'(bus.pc_addr), 32'(pcs[i]));
    end
    bus.ret_req = 1'b0;
    chk("no_fault", 32'(bus.fault), 0);
    bus.call_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.branch_target = 5'(tg[i]);
      step(1);
    end
    bus.branch_target = 5'd30;
    step(1);
    bus.call_req = 1'b0;
    chk("ovf_fault", 32'(bus.fault), 1);
    chk("ovf_halted", 32'(bus.halted), 1);
    chk("ovf_pc", 32'(bus.pc_addr), 24);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("fault_cleared", 32'(bus.fault), 0);
    bus.ret_req = 1'b1;
    step(1);
    bus.ret_req = 1'b0;
    chk("unf_fault", 32'(bus.fault), 1);
    chk("unf_halted", 32'(bus.halted), 1);
`else
    tg = '{9, 0, 0, 0};
    bus.call_req = 1'b1;
    bus.branch_target = 5'(tg[0]);
    step(1);
    chk("call_ignored_pc", 32'(bus.pc_addr), 1);
    bus.call_req = 1'b0;
    bus.ret_req = 1'b1;
    step(1);
    bus.ret_req = 1'b0;
    chk("ret_ignored_pc", 32'(bus.pc_addr), 1);
    chk("fault_tied", 32'(bus.fault), 0);
    chk("ret_no_halt", 32'(bus.halted), 0);
`endif

    step(1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
